// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter feeding one shared FP16+FP16->FP32 adder through a registered issue stage.
// Define FP_ADD_ARBITER_OUT_REG_EN to add a registered response stage after the adder.

package fp_add_arbiter_pkg;
    typedef enum logic [2:0] {FP32, FP64, FP16, E5M2, FP16ALT, E4M3} fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            E5M2, E4M3:    return 8;
            default:       return 32;
        endcase
    endfunction
endpackage

// Exact-sum adder: both FP16 operands are widened to a 2^-24-weighted fixed-point
// magnitude, added exactly, then normalised and RNE-rounded into FP32.
module fp_add #(
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatA   = fp_add_arbiter_pkg::FP16,
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatB   = fp_add_arbiter_pkg::FP16,
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatOut = fp_add_arbiter_pkg::FP32,
    parameter int unsigned WidthA   = fp_add_arbiter_pkg::fp_width(FpFormatA),
    parameter int unsigned WidthB   = fp_add_arbiter_pkg::fp_width(FpFormatB),
    parameter int unsigned WidthOut = fp_add_arbiter_pkg::fp_width(FpFormatOut)
) (
    input  logic [WidthA-1:0]   i_a,
    input  logic [WidthB-1:0]   i_b,
    output logic [WidthOut-1:0] o_res
);
    function automatic logic [39:0] fp16_mag(input logic [15:0] x);
        logic [10:0] sig;
        logic [4:0]  sh;
        sig = {(x[14:10] != 5'd0), x[9:0]};
        sh  = (x[14:10] == 5'd0) ? 5'd0 : x[14:10] - 5'd1;
        return {29'd0, sig} << sh;
    endfunction

    logic [39:0] w_mag_a, w_mag_b;
    logic [40:0] w_sum;
    logic        w_sign;
    logic [5:0]  w_lead;
    logic [39:0] w_norm;
    logic [22:0] w_man_trunc;
    logic        w_guard, w_sticky, w_round_up;
    logic [23:0] w_man_rnd;
    logic [7:0]  w_exp;
    logic [31:0] w_finite;
    logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_mag_a = fp16_mag(i_a);
    assign w_mag_b = fp16_mag(i_b);
    assign w_a_inf = (i_a[14:10] == 5'h1f) && (i_a[9:0] == 10'd0);
    assign w_b_inf = (i_b[14:10] == 5'h1f) && (i_b[9:0] == 10'd0);
    assign w_a_nan = (i_a[14:10] == 5'h1f) && (i_a[9:0] != 10'd0);
    assign w_b_nan = (i_b[14:10] == 5'h1f) && (i_b[9:0] != 10'd0);

    always_comb begin
        w_sum  = '0;
        w_sign = 1'b0;
        if (i_a[15] == i_b[15]) begin
            w_sum  = {1'b0, w_mag_a} + {1'b0, w_mag_b};
            w_sign = i_a[15];
        end else if (w_mag_a >= w_mag_b) begin
            w_sum  = {1'b0, w_mag_a - w_mag_b};
            w_sign = i_a[15];
        end else begin
            w_sum  = {1'b0, w_mag_b - w_mag_a};
            w_sign = i_b[15];
        end
    end

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < 41; i++) begin
            if (w_sum[i]) w_lead = 6'(i);
        end
    end

    // The leading one is shifted out of the top; what remains is the fraction.
    assign w_norm      = w_sum[39:0] << (6'd40 - w_lead);
    assign w_man_trunc = w_norm[39:17];
    assign w_guard     = w_norm[16];
    assign w_sticky    = |w_norm[15:0];
    assign w_round_up  = w_guard & (w_sticky | w_man_trunc[0]);
    assign w_man_rnd   = {1'b0, w_man_trunc} + {23'd0, w_round_up};
    assign w_exp       = 8'(w_lead) + 8'd103 + {7'd0, w_man_rnd[23]};
    assign w_finite    = (w_sum == '0) ? {i_a[15] & i_b[15], 31'd0}
                                       : {w_sign, w_exp, w_man_rnd[22:0]};

    always_comb begin
        o_res = w_finite;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[15] != i_b[15]))) begin
            o_res = 32'h7fc0_0000;
        end else if (w_a_inf) begin
            o_res = {i_a[15], 8'hff, 23'd0};
        end else if (w_b_inf) begin
            o_res = {i_b[15], 8'hff, 23'd0};
        end
    end
endmodule

module fp_add_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatA   = fp_add_arbiter_pkg::FP16,
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatB   = fp_add_arbiter_pkg::FP16,
    parameter fp_add_arbiter_pkg::fp_format_e FpFormatOut = fp_add_arbiter_pkg::FP32,
    parameter int unsigned IdWidth  = $clog2(NumReq),
    parameter int unsigned WidthA   = fp_add_arbiter_pkg::fp_width(FpFormatA),
    parameter int unsigned WidthB   = fp_add_arbiter_pkg::fp_width(FpFormatB),
    parameter int unsigned WidthOut = fp_add_arbiter_pkg::fp_width(FpFormatOut)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq-1:0][WidthA-1:0]  req_a_i,
    input  logic [NumReq-1:0][WidthB-1:0]  req_b_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [IdWidth-1:0]             rsp_id_o,
    output logic [WidthOut-1:0]            rsp_result_o,
    output logic [31:0]                    op_count_o
);
    logic [IdWidth-1:0]  r_rr;
    logic                r_s1_valid;
    logic [WidthA-1:0]   r_s1_a;
    logic [WidthB-1:0]   r_s1_b;
    logic [IdWidth-1:0]  r_s1_id;
    logic [31:0]         r_op_count;

    logic [NumReq-1:0]   w_grant;
    logic [IdWidth-1:0]  w_grant_idx;
    logic                w_grant_any;
    logic [IdWidth:0]    w_cand;
    logic [IdWidth:0]    w_rr_inc;
    logic [IdWidth-1:0]  w_next_rr;
    logic                w_issue_can_accept;
    logic                w_hs;
    logic                w_s1_fire;
    logic [WidthOut-1:0] w_add_res;

    // Cyclic search starting at the pointer; candidate index wraps past NumReq-1.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_cand = {1'b0, r_rr} + (IdWidth+1)'(k);
            if (w_cand >= (IdWidth+1)'(NumReq)) w_cand = w_cand - (IdWidth+1)'(NumReq);
            if (!w_grant_any && req_valid_i[w_cand[IdWidth-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[IdWidth-1:0];
            end
        end
    end

    assign w_grant            = w_grant_any ? (NumReq'(1) << w_grant_idx) : '0;
    assign w_issue_can_accept = !r_s1_valid || w_s1_fire;
    assign req_ready_o        = w_grant & {NumReq{w_issue_can_accept}};
    assign w_hs               = w_grant_any && w_issue_can_accept;
    assign w_rr_inc           = {1'b0, w_grant_idx} + (IdWidth+1)'(1);
    assign w_next_rr          = (w_rr_inc == (IdWidth+1)'(NumReq)) ? '0 : w_rr_inc[IdWidth-1:0];
    assign op_count_o         = r_op_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_op_count <= '0;
        end else begin
            if (w_hs) begin
                r_rr       <= w_next_rr;
                r_op_count <= r_op_count + 32'd1;
                r_s1_valid <= 1'b1;
                r_s1_a     <= req_a_i[w_grant_idx];
                r_s1_b     <= req_b_i[w_grant_idx];
                r_s1_id    <= w_grant_idx;
            end else if (w_s1_fire) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    fp_add #(
        .FpFormatA   (FpFormatA),
        .FpFormatB   (FpFormatB),
        .FpFormatOut (FpFormatOut),
        .WidthA      (WidthA),
        .WidthB      (WidthB),
        .WidthOut    (WidthOut)
    ) u_fp_add (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_res (w_add_res)
    );

`ifdef FP_ADD_ARBITER_OUT_REG_EN
    logic                r_s2_valid;
    logic [IdWidth-1:0]  r_s2_id;
    logic [WidthOut-1:0] r_s2_res;

    assign w_s1_fire = r_s1_valid && (!r_s2_valid || rsp_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_res   <= '0;
        end else if (w_s1_fire) begin
            r_s2_valid <= 1'b1;
            r_s2_id    <= r_s1_id;
            r_s2_res   <= w_add_res;
        end else if (rsp_ready_i) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign rsp_valid_o  = r_s2_valid;
    assign rsp_id_o     = r_s2_id;
    assign rsp_result_o = r_s2_res;
`else
    assign w_s1_fire    = r_s1_valid && rsp_ready_i;
    assign rsp_valid_o  = r_s1_valid;
    assign rsp_id_o     = r_s1_id;
    assign rsp_result_o = w_add_res;
`endif
endmodule
